bp_table_arbiter: RTL and testbench
===================================

Name: bp_table_arbiter

Overview:
- Sequences access to the single-ported prediction-counter table shared by IF-stage lookups and MEM-stage resolution updates.
- Buffers MEM updates in a small FIFO and applies saturating-counter updates.
- Maintains the global history register.
- Runs a table-clear sweep after reset or on request.
- Sits between the IF/MEM pipeline stages and the branch-prediction tables.

Parameters:
- s_index, 10, table index width; table depth = 2**s_index.
- n_previous_branches, 4, global history register width.
- DEPTH, 4, update FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- if_lookup_req  in  1  IF requests a table read this cycle.
- if_lookup_idx  in  s_index  IF read index.
- if_lookup_gnt  out  1  combinational; lookup granted this cycle.
- upd_valid  in  1  MEM resolved branch update offered.
- upd_idx  in  s_index  index to update.
- upd_taken  in  1  actual branch outcome.
- upd_old_ctr  in  2  counter value read at prediction time.
- upd_ready  out  1  combinational; update accepted when upd_valid && upd_ready.
- clear_req  in  1  restart clear sweep; single-cycle pulse.
- tbl_en  out  1  registered; table access enable.
- tbl_we  out  1  registered; 1 = write, 0 = read.
- tbl_addr  out  s_index  registered; table address.
- tbl_wdata  out  2  registered; counter write data.
- ghr  out  n_previous_branches  global history, newest outcome in bit 0.
- busy_clearing  out  1  high while in CLEAR.
- fifo_count  out  $clog2(DEPTH+1)  occupancy.

Behaviour:
- Reset (rst=0, async) values:
  - state=CLEAR, clr_ptr=0.
  - tbl_en=0, tbl_we=0, tbl_addr=0, tbl_wdata=0.
  - ghr=0, fifo_count=0, busy_clearing=1, if_lookup_gnt=0.
  - upd_ready=1 unless clear_req.
- FSM states CLEAR and RUN. Each cycle a decision is made; the tbl_* outputs register that decision at the next edge (1-cycle latency).
- CLEAR:
  - Decision is a write of addr=clr_ptr, wdata=2'b01 (weakly not-taken); clr_ptr increments.
  - if_lookup_gnt=0; FIFO does not drain; enqueue still allowed.
  - When clr_ptr == 2**s_index-1 the state goes to RUN. The sweep lasts exactly 2**s_index cycles.
- RUN priority, evaluated in order:
  1. fifo_count==DEPTH: drain the FIFO head as a write; if_lookup_gnt=0.
  2. Else if_lookup_req: gnt=1; decision is read of if_lookup_idx.
  3. Else FIFO non-empty: drain the head as a write.
  4. Else idle, tbl_en=0.
- Drain write data is the saturating counter update of the head entry:
  - Taken: min(3, old+1).
  - Not taken: max(0, old-1).
  - Address is the head entry's upd_idx.
- FIFO:
  - upd_ready = (fifo_count<DEPTH) && !clear_req; there is no same-cycle bypass when full.
  - Enqueue and dequeue in the same cycle leave the count unchanged.
  - Read and write pointers wrap modulo DEPTH.
- GHR: on each accepted update, ghr <= {ghr[n_previous_branches-2:0], upd_taken}. The shift happens at accept time, not drain time.
- clear_req (either state):
  - Next state=CLEAR, clr_ptr=0, FIFO flushed (count 0), ghr=0.
  - A same-cycle update is not accepted.
  - clear_req during CLEAR restarts the sweep at address 0.
- Reset asserted mid-operation aborts everything immediately to reset values; FIFO contents are discarded.

Test Plan:
All scenarios use s_index=4, n_previous_branches=4, DEPTH=4.
- Release reset, idle inputs -> tbl writes addr 0..15 with wdata 01 on 16 consecutive cycles; gnt=0 throughout; busy_clearing falls after the addr-15 write decision; next cycle tbl_en=0.
- RUN with fifo_count=1, if_lookup_req=1 idx=5 -> gnt=1; next cycle tbl_en=1, we=0, addr=5. Drop the req -> following cycle the FIFO head is written and fifo_count=0.
- Updates (old=3,T), (old=0,N), (old=1,T), (old=2,N), drained with lookups idle -> wdata 3, 0, 2, 1 respectively.
- if_lookup_req held high, 4 updates enqueued -> upd_ready=0 and gnt=0 while count=4. Head is written the next cycle and count=3, after which gnt=1 resumes with no further updates.
- Accepted outcomes T,N,T,T from ghr=0 -> ghr=4'b1011.
- clear_req in RUN with fifo_count=3 and upd_valid=1 -> update not accepted; next cycle fifo_count=0, ghr=0, busy_clearing=1; sweep restarts at addr 0.

Source files
------------

// File: rtl/bp_table_arbiter.sv
// Arbiter for the single-ported branch-prediction counter table: IF lookups,
// buffered MEM counter updates, global history and the table-clear sweep.
module bp_table_arbiter #(
  parameter int unsigned s_index             = 10,
  parameter int unsigned n_previous_branches = 4,
  parameter int unsigned DEPTH               = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                if_lookup_req,
  input  logic [s_index-1:0]                  if_lookup_idx,
  output logic                                if_lookup_gnt,
  input  logic                                upd_valid,
  input  logic [s_index-1:0]                  upd_idx,
  input  logic                                upd_taken,
  input  logic [1:0]                          upd_old_ctr,
  output logic                                upd_ready,
  input  logic                                clear_req,
  output logic                                tbl_en,
  output logic                                tbl_we,
  output logic [s_index-1:0]                  tbl_addr,
  output logic [1:0]                          tbl_wdata,
  output logic [n_previous_branches-1:0]      ghr,
  output logic                                busy_clearing,
  output logic [$clog2(DEPTH+1)-1:0]          fifo_count
);

  localparam int unsigned CW       = $clog2(DEPTH + 1);
  localparam int unsigned PW       = $clog2(DEPTH);
  localparam int unsigned NH       = n_previous_branches;
  localparam int unsigned TBL_LAST = (1 << s_index) - 1;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  typedef struct packed {
    logic [s_index-1:0] idx;
    logic               taken;
    logic [1:0]         ctr;
  } upd_t;

  logic [0:0]         state_q, state_d;
  logic [s_index-1:0] clr_ptr_q, clr_ptr_d;
  logic               en_q, en_d;
  logic               we_q, we_d;
  logic [s_index-1:0] addr_q, addr_d;
  logic [1:0]         wdata_q, wdata_d;
  logic [NH-1:0]      ghr_q, ghr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  upd_t               fifo_q [DEPTH];

  upd_t       head;
  logic [1:0] head_ctr_next;
  logic       full, empty, accept, deq, gnt;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == CW'(0));
  assign accept = upd_valid && upd_ready;
  assign head   = fifo_q[rd_ptr_q];

  assign upd_ready     = !full && !clear_req;
  assign if_lookup_gnt = gnt;
  assign busy_clearing = (state_q == ST_CLEAR);
  assign tbl_en        = en_q;
  assign tbl_we        = we_q;
  assign tbl_addr      = addr_q;
  assign tbl_wdata     = wdata_q;
  assign ghr           = ghr_q;
  assign fifo_count    = count_q;

  // Saturating 2-bit counter update of the FIFO head entry
  always_comb begin
    head_ctr_next = head.ctr;
    if (head.taken) begin
      if (head.ctr != 2'd3) head_ctr_next = head.ctr + 2'd1;
    end else begin
      if (head.ctr != 2'd0) head_ctr_next = head.ctr - 2'd1;
    end
  end

  // Next-state and table-access decision for this cycle
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    en_d      = 1'b0;
    we_d      = 1'b0;
    addr_d    = '0;
    wdata_d   = 2'b00;
    deq       = 1'b0;
    gnt       = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        en_d      = 1'b1;
        we_d      = 1'b1;
        addr_d    = clr_ptr_q;
        wdata_d   = 2'b01;
        clr_ptr_d = clr_ptr_q + s_index'(1);
        if (clr_ptr_q == s_index'(TBL_LAST)) state_d = ST_RUN;
      end
      default: begin
        if (full) begin
          deq = 1'b1;
        end else if (if_lookup_req) begin
          gnt    = 1'b1;
          en_d   = 1'b1;
          addr_d = if_lookup_idx;
        end else if (!empty) begin
          deq = 1'b1;
        end
      end
    endcase
    if (deq) begin
      en_d    = 1'b1;
      we_d    = 1'b1;
      addr_d  = head.idx;
      wdata_d = head_ctr_next;
    end
    if (clear_req) begin
      state_d   = ST_CLEAR;
      clr_ptr_d = '0;
    end
  end

  // FIFO bookkeeping and history shift at update-accept time
  always_comb begin
    count_d  = count_q + CW'(accept) - CW'(deq);
    wr_ptr_d = accept ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = deq ? rd_ptr_q + PW'(1) : rd_ptr_q;
    ghr_d    = accept ? {ghr_q[NH-2:0], upd_taken} : ghr_q;
    if (clear_req) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ghr_d    = '0;
    end
  end

  // State, pointers and registered table-interface outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      en_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 2'b00;
      ghr_q     <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      en_q      <= en_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ghr_q     <= ghr_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // FIFO payload storage; validity is tracked by the count, so no reset
  always_ff @(posedge clk) begin
    if (accept) fifo_q[wr_ptr_q] <= '{idx: upd_idx, taken: upd_taken, ctr: upd_old_ctr};
  end

endmodule

// File: tb/tb_bp_table_arbiter.sv
// Self-checking bench for bp_table_arbiter with a queue-based reference model.
module tb_bp_table_arbiter;

  logic       clk;
  logic       rst;
  logic       if_lookup_req;
  logic [3:0] if_lookup_idx;
  logic       if_lookup_gnt;
  logic       upd_valid;
  logic [3:0] upd_idx;
  logic       upd_taken;
  logic [1:0] upd_old_ctr;
  logic       upd_ready;
  logic       clear_req;
  logic       tbl_en;
  logic       tbl_we;
  logic [3:0] tbl_addr;
  logic [1:0] tbl_wdata;
  logic [3:0] ghr;
  logic       busy_clearing;
  logic [2:0] fifo_count;

  bp_table_arbiter #(.s_index(4), .n_previous_branches(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .if_lookup_req(if_lookup_req), .if_lookup_idx(if_lookup_idx), .if_lookup_gnt(if_lookup_gnt),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_old_ctr(upd_old_ctr),
    .upd_ready(upd_ready), .clear_req(clear_req),
    .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .ghr(ghr), .busy_clearing(busy_clearing), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int taken;
    int ctr;
  } ent_t;

  // Reference model: pending updates as a queue, expected registered outputs
  ent_t q[$];
  bit   m_clearing;
  int   m_clr;
  int   m_ghr;
  bit   m_en;
  bit   m_we;
  int   m_addr;
  int   m_wdata;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int taken, input int ctr);
    if (taken != 0) return (ctr >= 3) ? 3 : ctr + 1;
    return (ctr <= 0) ? 0 : ctr - 1;
  endfunction

  task automatic m_reset();
    q.delete();
    m_clearing = 1'b1;
    m_clr      = 0;
    m_ghr      = 0;
    m_en       = 1'b0;
    m_we       = 1'b0;
    m_addr     = 0;
    m_wdata    = 0;
  endtask

  task automatic chk_reset_values();
    chk("rst_tbl_en", tbl_en, 0);
    chk("rst_tbl_we", tbl_we, 0);
    chk("rst_tbl_addr", tbl_addr, 0);
    chk("rst_tbl_wdata", tbl_wdata, 0);
    chk("rst_ghr", ghr, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", busy_clearing, 1);
    chk("rst_gnt", if_lookup_gnt, 0);
    chk("rst_ready", upd_ready, 1);
  endtask

  // One clock cycle: apply inputs, check against model at negedge, advance model
  task automatic cyc(input bit req, input int lidx, input bit v, input int uidx,
                     input bit tk, input int old, input bit clr);
    bit   full, e_ready, e_gnt, n_en, n_we;
    int   n_addr, n_wd;
    ent_t h;
    if_lookup_req = req;
    if_lookup_idx = 4'(lidx);
    upd_valid     = v;
    upd_idx       = 4'(uidx);
    upd_taken     = tk;
    upd_old_ctr   = 2'(old);
    clear_req     = clr;
    @(negedge clk);
    full    = (q.size() == 4);
    e_ready = !full && !clr;
    e_gnt   = !m_clearing && !full && req;
    chk("gnt", if_lookup_gnt, e_gnt);
    chk("ready", upd_ready, e_ready);
    chk("busy", busy_clearing, m_clearing);
    chk("count", fifo_count, q.size());
    chk("ghr", ghr, m_ghr);
    chk("tbl_en", tbl_en, m_en);
    if (m_en) begin
      chk("tbl_we", tbl_we, m_we);
      chk("tbl_addr", tbl_addr, m_addr);
      if (m_we) chk("tbl_wdata", tbl_wdata, m_wdata);
    end
    n_en = 0; n_we = 0; n_addr = 0; n_wd = 0;
    if (m_clearing) begin
      n_en = 1; n_we = 1; n_addr = m_clr; n_wd = 1;
    end else if (full || (!req && q.size() > 0)) begin
      h = q.pop_front();
      n_en = 1; n_we = 1; n_addr = h.idx; n_wd = sat(h.taken, h.ctr);
    end else if (req) begin
      n_en = 1; n_addr = lidx;
    end
    if (v && e_ready) begin
      q.push_back('{uidx, int'(tk), old});
      m_ghr = ((m_ghr << 1) | int'(tk)) & 15;
    end
    if (clr) begin
      q.delete();
      m_ghr      = 0;
      m_clearing = 1;
      m_clr      = 0;
    end else if (m_clearing) begin
      if (m_clr == 15) m_clearing = 0;
      m_clr = (m_clr + 1) % 16;
    end
    m_en = n_en; m_we = n_we; m_addr = n_addr; m_wdata = n_wd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int olds[4] = '{3, 0, 1, 2};
    bit tks[4]  = '{1, 0, 1, 0};
    int exps[4] = '{3, 0, 2, 1};
    bit pat[4]  = '{1, 0, 1, 1};

    rst = 1'b1;
    if_lookup_req = 0; if_lookup_idx = 0; upd_valid = 0; upd_idx = 0;
    upd_taken = 0; upd_old_ctr = 0; clear_req = 0;
    #2 rst = 1'b0;
    #1 chk_reset_values();
    clear_req = 1'b1;
    #1 chk("rst_ready_clr", upd_ready, 0);
    clear_req = 1'b0;
    m_reset();
    @(posedge clk); #1;
    rst = 1'b1;

    // Post-reset sweep of all 16 entries, then idle
    idle(17);
    chk("sweep_done", busy_clearing, 0);

    // Lookup preempts a pending update, then each update drains with its counter
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 1, 8 + k, tks[k], olds[k], 0);
      if (k == 0) cyc(1, 5, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("drain_wdata", tbl_wdata, exps[k]);
      chk("drain_addr", tbl_addr, 8 + k);
    end
    idle(2);

    // Lookups held high while the FIFO fills; full FIFO forces a drain
    for (int k = 0; k < 4; k++) cyc(1, 7, 1, k, pat[k], k, 0);
    chk("ghr_pattern", ghr, 4'b1011);
    chk("full_count", fifo_count, 4);
    cyc(1, 7, 1, 12, 1, 2, 0);
    chk("after_full_count", fifo_count, 3);
    cyc(1, 7, 0, 0, 0, 0, 0);

    // Clear request with three pending updates and an update offered
    cyc(1, 7, 1, 13, 1, 1, 1);
    chk("clr_count", fifo_count, 0);
    chk("clr_ghr", ghr, 0);
    chk("clr_busy", busy_clearing, 1);
    idle(5);
    cyc(0, 0, 1, 3, 1, 0, 1);
    idle(18);

    // Randomized traffic with occasional clear requests
    for (int i = 0; i < 400; i++)
      cyc(bit'($urandom_range(1)), int'($urandom_range(15)), bit'($urandom_range(1)),
          int'($urandom_range(15)), bit'($urandom_range(1)), int'($urandom_range(3)),
          ($urandom_range(63) == 0));

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) cyc(1, 2, 1, i, 1, 1, 0);
    if_lookup_req = 0; upd_valid = 0; clear_req = 0;
    #3 rst = 1'b0;
    #1 chk_reset_values();
    m_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    idle(18);
    for (int i = 0; i < 100; i++)
      cyc(bit'($urandom_range(1)), int'($urandom_range(15)), bit'($urandom_range(1)),
          int'($urandom_range(15)), bit'($urandom_range(1)), int'($urandom_range(3)), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
